// File: rtl/miriscv_comdecode_pkg.sv
// Shared decode types for the M-extension unit: operation codes, MDU FSM states, divider step count.
package miriscv_comdecode_pkg;

    localparam int         MDU_DIV_STEPS = 32;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // {funct3, funct7}
    typedef enum logic [9:0] {
        ALU_ADD    = {3'b000, 7'b0000000},
        ALU_SUB    = {3'b000, 7'b0100000},
        ALU_MUL    = {3'b000, 7'b0000001},
        ALU_MULH   = {3'b001, 7'b0000001},
        ALU_MULHSU = {3'b010, 7'b0000001},
        ALU_MULHU  = {3'b011, 7'b0000001},
        ALU_DIV    = {3'b100, 7'b0000001},
        ALU_DIVU   = {3'b101, 7'b0000001},
        ALU_REM    = {3'b110, 7'b0000001},
        ALU_REMU   = {3'b111, 7'b0000001}
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX,
        DONE
    } mdu_state_t;

endpackage

// File: rtl/miriscv_div_step.sv
// One combinational restoring shift-subtract divider step on {remainder, quotient, divisor}.
// Zero latency; no handshake.
module miriscv_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] dvs_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // rem < dvs holds between steps, so the top bit of diff is a clean borrow
    assign shifted = {rem_i, quo_i[XLEN-1]};
    assign diff    = shifted - {1'b0, dvs_i};
    assign quo_o   = {quo_i[XLEN-2:0], ~diff[XLEN]};
    assign rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];

endmodule

// File: rtl/miriscv_mdu_seq.sv
// Sequential RV32 M-extension unit: multiply 1 cycle, divide 34 cycles; kill_i aborts, no backpressure.
// MIRISCV_MDU_EARLY_OUT_EN: divide-by-zero / signed overflow finish in 1 cycle.
module miriscv_mdu_seq
    import miriscv_comdecode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            arstn_i,
    input  logic            req_i,
    input  alu_op_t         op_i,
    input  logic [XLEN-1:0] opa_i,
    input  logic [XLEN-1:0] opb_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    mdu_state_t      state_q;
    logic [4:0]      cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, dvs_q, res_q, out_q;
    logic            is_rem_q, qneg_q, rneg_q;
    logic [XLEN-1:0] rem_d, quo_d;

    logic [2:0]        funct3;
    logic              accept, div_sgn, opa_neg, opb_neg, a_sgn, b_sgn;
    logic [XLEN-1:0]   opa_mag, opb_mag;
    logic [2*XLEN-1:0] mul_a, mul_b, mul_p;

    assign funct3  = op_i[9:7];
    assign accept  = (state_q == IDLE) && req_i && !kill_i && (op_i[6:0] == FUNCT7_MULDIV);

    // A modulo-2^64 product of the sign/zero-extended operands equals the low 64 bits of the 33x33 signed product
    assign a_sgn   = (funct3[1:0] != 2'b11);
    assign b_sgn   = !funct3[1];
    assign mul_a   = {{XLEN{a_sgn & opa_i[XLEN-1]}}, opa_i};
    assign mul_b   = {{XLEN{b_sgn & opb_i[XLEN-1]}}, opb_i};
    assign mul_p   = mul_a * mul_b;

    assign div_sgn = !funct3[0];
    assign opa_neg = div_sgn & opa_i[XLEN-1];
    assign opb_neg = div_sgn & opb_i[XLEN-1];
    assign opa_mag = opa_neg ? -opa_i : opa_i;
    assign opb_mag = opb_neg ? -opb_i : opb_i;

`ifdef MIRISCV_MDU_EARLY_OUT_EN
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] early_res;
    assign div_zero  = (opb_i == '0);
    assign div_ovf   = div_sgn && (opa_i == {1'b1, {(XLEN-1){1'b0}}}) && (opb_i == '1);
    assign early_res = div_zero ? (funct3[1] ? opa_i : '1) : (funct3[1] ? '0 : opa_i);
`endif

    miriscv_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_d),
        .quo_o (quo_d)
    );

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            res_q    <= '0;
            out_q    <= '0;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
        end else if (kill_i && (state_q != IDLE)) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    is_rem_q <= funct3[1];
                    if (!funct3[2]) begin
                        res_q   <= (funct3[1:0] == 2'b00) ? mul_p[XLEN-1:0] : mul_p[2*XLEN-1:XLEN];
                        state_q <= DONE;
`ifdef MIRISCV_MDU_EARLY_OUT_EN
                    end else if (div_zero || div_ovf) begin
                        res_q   <= early_res;
                        state_q <= DONE;
`endif
                    end else begin
                        rem_q   <= '0;
                        quo_q   <= opa_mag;
                        dvs_q   <= opb_mag;
                        qneg_q  <= opa_neg ^ opb_neg;
                        rneg_q  <= opa_neg;
                        cnt_q   <= 5'(MDU_DIV_STEPS - 1);
                        state_q <= DIV;
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) state_q <= FIX;
                    else             cnt_q   <= cnt_q - 5'd1;
                end
                FIX: begin
                    // A zero divisor leaves rem = |opa|, so only the quotient needs overriding
                    if (is_rem_q)           res_q <= rneg_q ? -rem_q : rem_q;
                    else if (dvs_q == '0)   res_q <= '1;
                    else                    res_q <= qneg_q ? -quo_q : quo_q;
                    state_q <= DONE;
                end
                DONE: begin
                    out_q   <= res_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q != IDLE);
    assign valid_o  = (state_q == DONE) && !kill_i;
    assign result_o = valid_o ? res_q : out_q;

endmodule

// File: tb/tb_miriscv_mdu_seq.sv
// Self-checking bench for miriscv_mdu_seq: directed vectors, corner sequences, random ops vs. arithmetic model.
module tb_miriscv_mdu_seq;
    import miriscv_comdecode_pkg::*;

`ifdef MIRISCV_MDU_EARLY_OUT_EN
    localparam int EO_LAT = 1;
`else
    localparam int EO_LAT = 34;
`endif

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        req = 1'b0;
    alu_op_t     op_s = ALU_ADD;
    logic [31:0] opa = '0, opb = '0;
    logic        kill = 1'b0;
    logic        busy_o, valid_o;
    logic [31:0] result_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] last_res = '0;

    always #5 clk = ~clk;

    miriscv_mdu_seq #(.XLEN(32)) dut (
        .clk_i    (clk),
        .arstn_i  (arstn),
        .req_i    (req),
        .op_i     (op_s),
        .opa_i    (opa),
        .opb_i    (opb),
        .kill_i   (kill),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            ALU_MUL:    begin p = sa * sb; return p[31:0];  end
            ALU_MULH:   begin p = sa * sb; return p[63:32]; end
            ALU_MULHSU: begin p = sa * ub; return p[63:32]; end
            ALU_MULHU:  begin u = {32'b0, a} * {32'b0, b}; return u[63:32]; end
            ALU_DIV:    begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            ALU_DIVU:   begin if (b == 0) return 32'hFFFFFFFF; p = ua / ub; return p[31:0]; end
            ALU_REM:    begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            ALU_REMU:   begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
            default:    return 32'h0;
        endcase
    endfunction

    function automatic int ref_lat(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        if (op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) return 1;
        sgn = (op == ALU_DIV) || (op == ALU_REM);
        if (b == 0 || (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF)) return EO_LAT;
        return 34;
    endfunction

    task automatic run_op(input string tag, input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat);
        int  lat;
        bit  busy_ok;
        @(posedge clk); #1;
        req = 1'b1; op_s = op; opa = a; opb = b;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (!busy_o) busy_ok = 1'b0;
            if (valid_o) begin
                lat = n;
                chk({tag, " result"}, result_o, exp_res);
                break;
            end
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy"}, {31'b0, busy_ok}, 32'd1);
        @(negedge clk);
        chk({tag, " strobe"}, {30'b0, valid_o, busy_o}, 32'd0);
        chk({tag, " held"}, result_o, exp_res);
        last_res = exp_res;
    endtask

    typedef struct {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int nval;
        bit seen;
        alu_op_t ops[8];
        logic [31:0] ra, rb;
        alu_op_t rop;

        vecs[0]  = '{ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1};
        vecs[1]  = '{ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1};
        vecs[2]  = '{ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1};
        vecs[3]  = '{ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1};
        vecs[4]  = '{ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
        vecs[5]  = '{ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
        vecs[6]  = '{ALU_REMU,   32'd100,      32'd7,        32'd2,        34};
        vecs[7]  = '{ALU_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        vecs[8]  = '{ALU_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34};
        vecs[9]  = '{ALU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, EO_LAT};
        vecs[10] = '{ALU_REM,    32'd5,        32'd0,        32'd5,        EO_LAT};
        vecs[11] = '{ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, EO_LAT};
        vecs[12] = '{ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        EO_LAT};
        vecs[13] = '{ALU_REMU,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, EO_LAT};
        ops = '{ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};

        #3;
        chk("reset outputs", {busy_o, valid_o, 30'b0} | result_o, 32'd0);
        @(negedge clk);
        arstn = 1'b1;

        for (int i = 0; i < 14; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

        // Non-M opcode must not start anything
        @(posedge clk); #1;
        req = 1'b1; op_s = ALU_SUB; opa = 32'd9; opb = 32'd3;
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("non-M ignored", {30'b0, busy_o, valid_o}, 32'd0);

        // kill at cycle 10 of a divide
        @(posedge clk); #1;
        req = 1'b1; op_s = ALU_DIV; opa = 32'd100; opb = 32'd7;
        @(posedge clk); #1;
        req = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        @(posedge clk); #1;
        kill = 1'b1;
        @(negedge clk);
        if (valid_o) seen = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill busy", {31'b0, busy_o}, 32'd0);
        chk("kill no valid", {31'b0, seen | valid_o}, 32'd0);
        chk("kill result kept", result_o, last_res);
        run_op("mul after kill", ALU_MUL, 32'd3, 32'd4, 32'd12, 1);

        // kill while in DONE drops the strobe
        @(posedge clk); #1;
        req = 1'b1; op_s = ALU_MUL; opa = 32'd5; opb = 32'd5;
        @(posedge clk); #1;
        req = 1'b0; kill = 1'b1;
        @(negedge clk);
        chk("kill in DONE valid", {31'b0, valid_o}, 32'd0);
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill in DONE idle", {30'b0, busy_o, valid_o}, 32'd0);
        chk("kill in DONE result", result_o, last_res);

        // reset at cycle 20 of a divide
        @(posedge clk); #1;
        req = 1'b1; op_s = ALU_DIVU; opa = 32'd1000; opb = 32'd3;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (19) @(posedge clk);
        #1 arstn = 1'b0;
        #1;
        chk("mid-op reset outputs", {busy_o, valid_o, 30'b0} | result_o, 32'd0);
        @(negedge clk);
        arstn = 1'b1;
        run_op("divu after reset", ALU_DIVU, 32'd9, 32'd3, 32'd3, 34);

        // req held high with a different op during a divide
        @(posedge clk); #1;
        req = 1'b1; op_s = ALU_DIV; opa = 32'hFFFFFFF9; opb = 32'd2;
        @(posedge clk); #1;
        op_s = ALU_MUL; opa = 32'd3; opb = 32'd4;
        nval = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            if (valid_o) begin
                nval++;
                chk("held req result", result_o, 32'hFFFFFFFD);
                chk("held req latency", n, 34);
                req = 1'b0;
            end
        end
        req = 1'b0;
        chk("held req one valid", nval, 32'd1);
        last_res = 32'hFFFFFFFD;

        // random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            rop = ops[$urandom_range(7)];
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(7))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = rb & 32'hFF;
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), rop, ra, rb, ref_res(rop, ra, rb), ref_lat(rop, ra, rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
